// File: rtl/mpm_pkg.sv
// Shared constants, slot record and address-split helpers for the banked multi-port memory.
package mpm_pkg;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 16;

    // Slot fields are sized for the widest supported configuration; users cast down.
    localparam int SLOT_ADDR_MAX = 32;
    localparam int SLOT_DATA_MAX = 64;

    typedef struct packed {
        logic                     valid;
        logic                     wen;
        logic [SLOT_ADDR_MAX-1:0] addr;
        logic [SLOT_DATA_MAX-1:0] wdata;
    } slot_t;

    function automatic int unsigned bank_of(input logic [SLOT_ADDR_MAX-1:0] addr,
                                            input int unsigned bw);
        return addr & ((32'd1 << bw) - 32'd1);
    endfunction

    function automatic int unsigned row_of(input logic [SLOT_ADDR_MAX-1:0] addr,
                                           input int unsigned bw);
        return addr >> bw;
    endfunction

endpackage

// File: rtl/mpm_bank.sv
// Single-port synchronous RAM bank with registered read data (held across writes).
module mpm_bank #(
    parameter int ROW_W  = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ROW_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[row] <= wdata;
            else    rdata    <= mem[row];
        end
    end

endmodule

// File: rtl/multi_ported_memory.sv
// N-port banked memory: per-port holding slot, rotating-priority bank arbiter, per-port responses.
// Optional write echo on out_valid/out_rdata when MPM_WRITE_ACK_EN is defined.
module multi_ported_memory
    import mpm_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        in_ready,
    input  logic [NUM_PORTS-1:0]        in_wen,
    input  logic [NUM_PORTS*ADDR_W-1:0] in_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] in_wdata,
    output logic [NUM_PORTS-1:0]        out_valid,
    output logic [NUM_PORTS*DATA_W-1:0] out_rdata
);

    localparam int BW  = $clog2(NUM_BANKS);
    localparam int BSW = (BW > 0) ? BW : 1;
    localparam int RW  = ADDR_W - BW;
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    slot_t              slot       [NUM_PORTS];
    logic [NUM_PORTS-1:0] slot_valid;
    logic [BSW-1:0]     slot_bank  [NUM_PORTS];
    logic [PW-1:0]      rr_ptr;
    logic [NUM_PORTS-1:0] grant;

    logic               bank_en    [NUM_BANKS];
    logic               bank_we    [NUM_BANKS];
    logic [RW-1:0]      bank_row   [NUM_BANKS];
    logic [DATA_W-1:0]  bank_wdata [NUM_BANKS];
    logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];

    logic [NUM_PORTS-1:0] resp_valid;
    logic [BSW-1:0]     resp_bank  [NUM_PORTS];
    logic [DATA_W-1:0]  resp_data  [NUM_PORTS];
    logic [DATA_W-1:0]  rdata_hold [NUM_PORTS];
`ifdef MPM_WRITE_ACK_EN
    logic [NUM_PORTS-1:0] resp_wr;
    logic [DATA_W-1:0]  resp_wdata [NUM_PORTS];
`endif

    always_comb begin
        slot_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            slot_valid[p] = slot[p].valid;
            slot_bank[p]  = BSW'(bank_of(slot[p].addr, BW));
        end
    end

    // Per bank, scan ports starting at rr_ptr; first valid slot hitting the bank wins.
    always_comb begin
        int  p;
        logic found;
        grant = '0;
        p     = 0;
        found = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]    = 1'b0;
            bank_we[b]    = 1'b0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            found         = 1'b0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                p = (int'(rr_ptr) + j) % NUM_PORTS;
                if (!found && slot[p].valid && int'(slot_bank[p]) == b) begin
                    found         = 1'b1;
                    grant[p]      = 1'b1;
                    bank_en[b]    = 1'b1;
                    bank_we[b]    = slot[p].wen;
                    bank_row[b]   = RW'(row_of(slot[p].addr, BW));
                    bank_wdata[b] = DATA_W'(slot[p].wdata);
                end
            end
        end
    end

    // Ready depends only on slot state and reset, never on in_valid.
    assign in_ready = ~slot_valid | grant | {NUM_PORTS{reset}};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) slot[p] <= '0;
            rr_ptr     <= '0;
            resp_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    slot[p].valid <= 1'b1;
                    slot[p].wen   <= in_wen[p];
                    slot[p].addr  <= SLOT_ADDR_MAX'(in_addr[p*ADDR_W +: ADDR_W]);
                    slot[p].wdata <= SLOT_DATA_MAX'(in_wdata[p*DATA_W +: DATA_W]);
                end else if (grant[p]) begin
                    slot[p].valid <= 1'b0;
                end
`ifdef MPM_WRITE_ACK_EN
                resp_valid[p] <= grant[p];
`else
                resp_valid[p] <= grant[p] & ~slot[p].wen;
`endif
            end
            if (|slot_valid)
                rr_ptr <= (rr_ptr == PW'(NUM_PORTS - 1)) ? '0 : rr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                resp_bank[p] <= slot_bank[p];
`ifdef MPM_WRITE_ACK_EN
                resp_wr[p]    <= slot[p].wen;
                resp_wdata[p] <= DATA_W'(slot[p].wdata);
`endif
            end
            if (reset)              rdata_hold[p] <= '0;
            else if (resp_valid[p]) rdata_hold[p] <= resp_data[p];
        end
    end

    always_comb begin
        out_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
`ifdef MPM_WRITE_ACK_EN
            resp_data[p] = resp_wr[p] ? resp_wdata[p] : bank_rdata[resp_bank[p]];
`else
            resp_data[p] = bank_rdata[resp_bank[p]];
`endif
            out_rdata[p*DATA_W +: DATA_W] = resp_valid[p] ? resp_data[p] : rdata_hold[p];
        end
    end

    assign out_valid = resp_valid;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mpm_bank #(.ROW_W(RW), .DATA_W(DATA_W)) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_multi_ported_memory.sv
// Directed self-checking bench for multi_ported_memory (default 3 ports, 4 banks, 12/16 bits).
module tb_multi_ported_memory;

    localparam int NP = 3;
    localparam int AW = 12;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    in_valid, in_ready, in_wen, out_valid;
    logic [NP*AW-1:0] in_addr;
    logic [NP*DW-1:0] in_wdata, out_rdata;

    int checks = 0;
    int errors = 0;

    logic [2:0] fair_exp [8] = '{3'b001, 3'b010, 3'b001, 3'b001,
                                 3'b010, 3'b001, 3'b001, 3'b010};

    multi_ported_memory u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wen    (in_wen),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_rdata (out_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_wen   = '0;
        in_addr  = '0;
        in_wdata = '0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        in_valid[p]         = 1'b1;
        in_wen[p]           = w;
        in_addr[p*AW +: AW] = a;
        in_wdata[p*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return out_rdata[p*DW +: DW];
    endfunction

    task automatic write_single(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_port(p, 1'b1, a, d);
        step();
        clear_inputs();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        check("rst_in_ready", in_ready, 3'b111);
        check("rst_out_valid", out_valid, 3'b000);
        check("rst_out_rdata", out_rdata, '0);
        reset = 1'b0;

        // basic write then read on another port
        set_port(0, 1'b1, 12'h004, 16'hA5A5);
        step();
        check("t1_ready_wr", in_ready, 3'b111);
        clear_inputs();
        step();
        set_port(1, 1'b0, 12'h004, 16'h0000);
        step();
        clear_inputs();
        check("t1_no_early_valid", out_valid, 3'b000);
        step();
        check("t1_valid", out_valid, 3'b010);
        check("t1_rdata", rd(1), 16'hA5A5);
        step();
        check("t1_valid_drop", out_valid, 3'b000);
        check("t1_rdata_hold", rd(1), 16'hA5A5);

        // parallel writes then streaming conflict-free reads
        set_port(0, 1'b1, 12'h001, 16'h1111);
        set_port(1, 1'b1, 12'h002, 16'h2222);
        set_port(2, 1'b1, 12'h003, 16'h3333);
        step();
        clear_inputs();
        step();
        step();
        set_port(0, 1'b0, 12'h001, 16'h0);
        set_port(1, 1'b0, 12'h002, 16'h0);
        set_port(2, 1'b0, 12'h003, 16'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_ready", in_ready, 3'b111);
            if (i > 0) begin
                check("t2_valid", out_valid, 3'b111);
                check("t2_rd0", rd(0), 16'h1111);
                check("t2_rd1", rd(1), 16'h2222);
                check("t2_rd2", rd(2), 16'h3333);
            end
        end
        clear_inputs();
        step();
        check("t2_last_valid", out_valid, 3'b111);
        step();
        check("t2_drained", out_valid, 3'b000);

        write_single(0, 12'h000, 16'h0F00);
        write_single(0, 12'h008, 16'h0F08);
        write_single(1, 12'h006, 16'h6666);

        // three-way conflict on bank 0 from rr_ptr = 0
        do_reset();
        set_port(0, 1'b0, 12'h000, 16'h0);
        set_port(1, 1'b0, 12'h004, 16'h0);
        set_port(2, 1'b0, 12'h008, 16'h0);
        step();
        check("t3_ready_c1", in_ready, 3'b001);
        clear_inputs();
        step();
        check("t3_valid_p0", out_valid, 3'b001);
        check("t3_rd0", rd(0), 16'h0F00);
        check("t3_ready_c2", in_ready, 3'b011);
        step();
        check("t3_valid_p1", out_valid, 3'b010);
        check("t3_rd1", rd(1), 16'hA5A5);
        check("t3_ready_c3", in_ready, 3'b111);
        step();
        check("t3_valid_p2", out_valid, 3'b100);
        check("t3_rd2", rd(2), 16'h0F08);
        step();
        check("t3_done", out_valid, 3'b000);

        // fairness: ports 0 and 1 hammer bank 2
        do_reset();
        set_port(0, 1'b0, 12'h002, 16'h0);
        set_port(1, 1'b0, 12'h006, 16'h0);
        step();
        check("t4_ready_c1", in_ready, 3'b101);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t4_grant_order", out_valid, fair_exp[i]);
            if (fair_exp[i][0]) check("t4_rd0", rd(0), 16'h2222);
            else                check("t4_rd1", rd(1), 16'h6666);
        end
        clear_inputs();
        step();
        step();
        step();

        // reset with all three slots pending
        do_reset();
        set_port(0, 1'b0, 12'h000, 16'h0);
        set_port(1, 1'b0, 12'h004, 16'h0);
        set_port(2, 1'b0, 12'h008, 16'h0);
        step();
        reset = 1'b1;
        clear_inputs();
        step();
        check("t5_valid_in_rst", out_valid, 3'b000);
        check("t5_ready_in_rst", in_ready, 3'b111);
        reset = 1'b0;
        step();
        check("t5_valid_after", out_valid, 3'b000);
        check("t5_ready_after", in_ready, 3'b111);
        step();
        check("t5_valid_late", out_valid, 3'b000);
        check("t5_rdata_cleared", out_rdata, '0);

        // write acknowledge behaviour, then read-after-write
        set_port(2, 1'b1, 12'h00C, 16'h1234);
        step();
        clear_inputs();
        set_port(2, 1'b0, 12'h00C, 16'h0);
        step();
        clear_inputs();
`ifdef MPM_WRITE_ACK_EN
        check("t6_wr_ack_valid", out_valid, 3'b100);
        check("t6_wr_ack_data", rd(2), 16'h1234);
`else
        check("t6_no_wr_ack", out_valid, 3'b000);
        check("t6_rdata_unchanged", rd(2), 16'h0000);
`endif
        step();
        check("t6_raw_valid", out_valid, 3'b100);
        check("t6_raw_data", rd(2), 16'h1234);
        step();
        check("t6_end_valid", out_valid, 3'b000);
        check("t6_end_hold", rd(2), 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
